// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
//   Raster timing bundle produced by vga_sync_gen and consumed by the
//   pixel/graphics stage.
//
//   p_tick       one-clk pulse per pixel period
//   x, y         current raster position (10 bits each)
//   en           visible-area flag
//   hsync/vsync  sync outputs at the configured polarity
//   line_start   one-clk pulse on the first clk where x shows 0
//   frame_start  one-clk pulse on the first clk where (x,y) shows (0,0)
//   frame_cnt    8-bit frame counter, wraps 255 -> 0
//
//   master : timing generator (drives everything)
//   slave  : graphics stage (observes everything)
// ---------------------------------------------------------------------------
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       en;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output p_tick, x, y, en, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    input p_tick, x, y, en, hsync, vsync, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator (640x480@60 by default). Divides the system
//   clock into a pixel tick, walks the raster and produces registered
//   position, visible-area and sync signals for the graphics stage.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   vga    master modport of vga_sync_gen_if (all outputs, all registered)
//
// Build option
//   VGA_SYNC_ALIGN_EN : when defined, en/hsync/vsync pass through one extra
//   register so they lag x/y by one clk, matching a one-cycle ROM read in
//   the graphics stage. x, y, p_tick, line_start, frame_start and frame_cnt
//   are never delayed. When undefined, en/hsync/vsync change on the same clk
//   as x/y.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  // Counters are 10 bits wide; reject timings that cannot fit.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             p_tick_q;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_next, y_next;
  logic             line_event, frame_event;
  logic             en_q, hsync_q, vsync_q;
  logic             line_start_q, frame_start_q;
  logic [7:0]       frame_cnt_q;
  logic             first_frame_q;  // next wrap to (0,0) opens frame 0

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    div_next    = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    x_next      = x_q;
    y_next      = y_q;
    line_event  = 1'b0;
    frame_event = 1'b0;
    if (p_tick_q) begin
      if (x_q == H_LAST) begin
        x_next     = '0;
        line_event = 1'b1;
        if (y_q == V_LAST) begin
          y_next      = '0;
          frame_event = 1'b1;
        end else begin
          y_next = y_q + 10'd1;
        end
      end else begin
        x_next = x_q + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the reset branch lists every register; there are no memories here,
  // so nothing is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt       <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      en_q          <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      first_frame_q <= 1'b1;
    end else begin
      div_cnt  <= div_next;
      // Registered from the next divider value so p_tick is high exactly
      // while div_cnt shows CLK_DIV-1.
      p_tick_q <= (div_next == DIV_LAST);
      x_q      <= x_next;
      y_q      <= y_next;
      // Decoded from next-state position so they land together with x/y.
      en_q     <= (x_next < H_VIS) && (y_next < V_VIS);
      hsync_q  <= (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
      vsync_q  <= (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
      // Event pulses last one clk, not a whole pixel period.
      line_start_q  <= line_event;
      frame_start_q <= frame_event;
      if (frame_event) begin
        first_frame_q <= 1'b0;
        if (!first_frame_q) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  assign vga.p_tick      = p_tick_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

`ifdef VGA_SYNC_ALIGN_EN
  // One extra clk on the sync/visible signals to match the graphics ROM.
  logic en_d, hsync_d, vsync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_d    <= 1'b0;
      hsync_d <= ~SYNC_ON;
      vsync_d <= ~SYNC_ON;
    end else begin
      en_d    <= en_q;
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign vga.en    = en_d;
  assign vga.hsync = hsync_d;
  assign vga.vsync = vsync_d;
`else
  assign vga.en    = en_q;
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
`endif

endmodule
